// File: rtl/mem_req_sched.sv
// Read/write request scheduler between the I/D cache miss ports and the AXI bridge.
// Fair I/D read arbitration with a single-entry writeback buffer that reads may bypass.
module mem_req_sched #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LINE_OFS   = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         icache_rd_req,
  input  logic [2:0]   icache_rd_type,
  input  logic [31:0]  icache_rd_addr,
  output logic         icache_rd_rdy,
  input  logic         dcache_rd_req,
  input  logic [2:0]   dcache_rd_type,
  input  logic [31:0]  dcache_rd_addr,
  output logic         dcache_rd_rdy,
  input  logic         dcache_wr_req,
  input  logic [2:0]   dcache_wr_type,
  input  logic [31:0]  dcache_wr_addr,
  input  logic [3:0]   dcache_wr_wstrb,
  input  logic [127:0] dcache_wr_data,
  output logic         dcache_wr_rdy,
  output logic         br_icache_rd_req,
  output logic [2:0]   br_icache_rd_type,
  output logic [31:0]  br_icache_rd_addr,
  input  logic         br_icache_rd_rdy,
  input  logic         br_icache_ret_last,
  output logic         br_dcache_rd_req,
  output logic [2:0]   br_dcache_rd_type,
  output logic [31:0]  br_dcache_rd_addr,
  input  logic         br_dcache_rd_rdy,
  input  logic         br_dcache_ret_last,
  output logic         br_dcache_wr_req,
  output logic [2:0]   br_dcache_wr_type,
  output logic [31:0]  br_dcache_wr_addr,
  output logic [3:0]   br_dcache_wr_wstrb,
  output logic [127:0] br_dcache_wr_data,
  input  logic         br_dcache_wr_rdy
);

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StRdReq  = 4'b0010,
    StRdWait = 4'b0100,
    StWrReq  = 4'b1000
  } state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e         state_q, state_d;
  logic           grant_i_q, grant_i_d;
  logic           last_grant_i_q, last_grant_i_d;
  logic [3:0]     bypass_cnt_q, bypass_cnt_d;
  logic           wb_valid_q, wb_valid_d;
  logic [2:0]     wb_type_q;
  logic [31:0]    wb_addr_q;
  logic [3:0]     wb_wstrb_q;
  logic [127:0]   wb_data_q;

  logic wb_capture, wb_clear;
  logic conf_i, conf_d, ok_i, ok_d, any_rd, pick_i;
  logic rd_i_act, rd_d_act, wr_act;

  function automatic logic line_eq(input logic [31:0] a, input logic [31:0] b);
    return a[31:LINE_OFS] == b[31:LINE_OFS];
  endfunction

  // A read conflicts with the buffered line or with a line being captured right now.
  always_comb begin
    wb_capture = dcache_wr_req & ~wb_valid_q;
    conf_i = icache_rd_req &
             ((wb_valid_q & line_eq(icache_rd_addr, wb_addr_q)) |
              (wb_capture & line_eq(icache_rd_addr, dcache_wr_addr)));
    conf_d = dcache_rd_req &
             ((wb_valid_q & line_eq(dcache_rd_addr, wb_addr_q)) |
              (wb_capture & line_eq(dcache_rd_addr, dcache_wr_addr)));
    ok_i   = icache_rd_req & ~conf_i;
    ok_d   = dcache_rd_req & ~conf_d;
    any_rd = icache_rd_req | dcache_rd_req;
    pick_i = ok_i & (~ok_d | ~last_grant_i_q);
  end

  always_comb begin
    state_d        = state_q;
    grant_i_d      = grant_i_q;
    last_grant_i_d = last_grant_i_q;
    bypass_cnt_d   = bypass_cnt_q;
    wb_clear       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wb_valid_q && (conf_i || conf_d || bypass_cnt_q == StarveMax || !any_rd)) begin
          state_d      = StWrReq;
          bypass_cnt_d = '0;
        end else if (ok_i || ok_d) begin
          state_d        = StRdReq;
          grant_i_d      = pick_i;
          last_grant_i_d = pick_i;
          if (wb_valid_q && bypass_cnt_q != StarveMax) bypass_cnt_d = bypass_cnt_q + 4'd1;
        end
      end
      StRdReq: begin
        if (grant_i_q ? br_icache_rd_rdy : br_dcache_rd_rdy) state_d = StRdWait;
      end
      StRdWait: begin
        if (grant_i_q ? br_icache_ret_last : br_dcache_ret_last) state_d = StIdle;
      end
      StWrReq: begin
        if (br_dcache_wr_rdy) begin
          wb_clear = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    wb_valid_d = wb_capture | (wb_valid_q & ~wb_clear);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      grant_i_q      <= 1'b0;
      last_grant_i_q <= 1'b1;  // makes the D-cache win the first tie
      bypass_cnt_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_type_q      <= '0;
      wb_addr_q      <= '0;
      wb_wstrb_q     <= '0;
      wb_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      grant_i_q      <= grant_i_d;
      last_grant_i_q <= last_grant_i_d;
      bypass_cnt_q   <= bypass_cnt_d;
      wb_valid_q     <= wb_valid_d;
      if (wb_capture) begin
        wb_type_q  <= dcache_wr_type;
        wb_addr_q  <= dcache_wr_addr;
        wb_wstrb_q <= dcache_wr_wstrb;
        wb_data_q  <= dcache_wr_data;
      end
    end
  end

  // Bridge-side payloads are zeroed whenever the matching request is idle.
  always_comb begin
    rd_i_act = (state_q == StRdReq) & grant_i_q;
    rd_d_act = (state_q == StRdReq) & ~grant_i_q;
    wr_act   = (state_q == StWrReq);

    br_icache_rd_req  = rd_i_act;
    br_icache_rd_type = rd_i_act ? icache_rd_type : 3'd0;
    br_icache_rd_addr = rd_i_act ? icache_rd_addr : 32'd0;
    icache_rd_rdy     = rd_i_act & br_icache_rd_rdy;

    br_dcache_rd_req  = rd_d_act;
    br_dcache_rd_type = rd_d_act ? dcache_rd_type : 3'd0;
    br_dcache_rd_addr = rd_d_act ? dcache_rd_addr : 32'd0;
    dcache_rd_rdy     = rd_d_act & br_dcache_rd_rdy;

    br_dcache_wr_req   = wr_act;
    br_dcache_wr_type  = wr_act ? wb_type_q : 3'd0;
    br_dcache_wr_addr  = wr_act ? wb_addr_q : 32'd0;
    br_dcache_wr_wstrb = wr_act ? wb_wstrb_q : 4'd0;
    br_dcache_wr_data  = wr_act ? wb_data_q : 128'd0;

    dcache_wr_rdy = ~wb_valid_q;
  end

endmodule

// File: tb/tb_mem_req_sched.sv
// Bench for mem_req_sched: queue-driven requesters, a simple bridge responder, a
// transaction-level model checked every cycle, and directed grant-order checks.
module tb_mem_req_sched;

  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned LINE_OFS   = 4;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         icache_rd_req = 1'b0;
  logic [2:0]   icache_rd_type = '0;
  logic [31:0]  icache_rd_addr = '0;
  logic         icache_rd_rdy;
  logic         dcache_rd_req = 1'b0;
  logic [2:0]   dcache_rd_type = '0;
  logic [31:0]  dcache_rd_addr = '0;
  logic         dcache_rd_rdy;
  logic         dcache_wr_req = 1'b0;
  logic [2:0]   dcache_wr_type = '0;
  logic [31:0]  dcache_wr_addr = '0;
  logic [3:0]   dcache_wr_wstrb = '0;
  logic [127:0] dcache_wr_data = '0;
  logic         dcache_wr_rdy;
  logic         br_icache_rd_req;
  logic [2:0]   br_icache_rd_type;
  logic [31:0]  br_icache_rd_addr;
  logic         br_icache_rd_rdy = 1'b0;
  logic         br_icache_ret_last = 1'b0;
  logic         br_dcache_rd_req;
  logic [2:0]   br_dcache_rd_type;
  logic [31:0]  br_dcache_rd_addr;
  logic         br_dcache_rd_rdy = 1'b0;
  logic         br_dcache_ret_last = 1'b0;
  logic         br_dcache_wr_req;
  logic [2:0]   br_dcache_wr_type;
  logic [31:0]  br_dcache_wr_addr;
  logic [3:0]   br_dcache_wr_wstrb;
  logic [127:0] br_dcache_wr_data;
  logic         br_dcache_wr_rdy = 1'b0;

  always #5 aclk = ~aclk;

  mem_req_sched #(.STARVE_MAX(STARVE_MAX), .LINE_OFS(LINE_OFS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type),
    .icache_rd_addr(icache_rd_addr), .icache_rd_rdy(icache_rd_rdy),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type),
    .dcache_rd_addr(dcache_rd_addr), .dcache_rd_rdy(dcache_rd_rdy),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_type(dcache_wr_type),
    .dcache_wr_addr(dcache_wr_addr), .dcache_wr_wstrb(dcache_wr_wstrb),
    .dcache_wr_data(dcache_wr_data), .dcache_wr_rdy(dcache_wr_rdy),
    .br_icache_rd_req(br_icache_rd_req), .br_icache_rd_type(br_icache_rd_type),
    .br_icache_rd_addr(br_icache_rd_addr), .br_icache_rd_rdy(br_icache_rd_rdy),
    .br_icache_ret_last(br_icache_ret_last),
    .br_dcache_rd_req(br_dcache_rd_req), .br_dcache_rd_type(br_dcache_rd_type),
    .br_dcache_rd_addr(br_dcache_rd_addr), .br_dcache_rd_rdy(br_dcache_rd_rdy),
    .br_dcache_ret_last(br_dcache_ret_last),
    .br_dcache_wr_req(br_dcache_wr_req), .br_dcache_wr_type(br_dcache_wr_type),
    .br_dcache_wr_addr(br_dcache_wr_addr), .br_dcache_wr_wstrb(br_dcache_wr_wstrb),
    .br_dcache_wr_data(br_dcache_wr_data), .br_dcache_wr_rdy(br_dcache_wr_rdy)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string ev_log = "";
  logic [31:0] i_q[$], d_q[$], w_q[$];
  logic s_i_req = 0, s_i_hs = 0, s_d_req = 0, s_d_hs = 0, s_w_req = 0, s_w_hs = 0;
  int   i_cnt = 0, d_cnt = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_log(input string name, input string exp);
    checks++;
    if (ev_log != exp) begin
      errors++;
      $display("FAIL %s: grant order got '%s' expected '%s'", name, ev_log, exp);
    end
  endtask

  function automatic logic [127:0] wdata(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 | {16'd0, a[15:0]}};
  endfunction

  // Requesters present the queue head; the bridge accepts each request on its second
  // cycle and returns the last beat two cycles after acceptance.
  always begin
    @(posedge aclk);
    #1;
    icache_rd_req   = (i_q.size() > 0);
    icache_rd_addr  = (i_q.size() > 0) ? i_q[0] : 32'd0;
    icache_rd_type  = 3'b100;
    dcache_rd_req   = (d_q.size() > 0);
    dcache_rd_addr  = (d_q.size() > 0) ? d_q[0] : 32'd0;
    dcache_rd_type  = dcache_rd_addr[6:4];
    dcache_wr_req   = (w_q.size() > 0);
    dcache_wr_addr  = (w_q.size() > 0) ? w_q[0] : 32'd0;
    dcache_wr_type  = 3'b100;
    dcache_wr_wstrb = dcache_wr_addr[15:12] | 4'b0001;
    dcache_wr_data  = wdata(dcache_wr_addr);
    if (!aresetn) begin
      br_icache_rd_rdy = 0; br_dcache_rd_rdy = 0; br_dcache_wr_rdy = 0;
      br_icache_ret_last = 0; br_dcache_ret_last = 0; i_cnt = 0; d_cnt = 0;
    end else begin
      br_icache_rd_rdy = s_i_req && !s_i_hs;
      br_dcache_rd_rdy = s_d_req && !s_d_hs;
      br_dcache_wr_rdy = s_w_req && !s_w_hs;
      if (s_i_hs) i_cnt = 2; else if (i_cnt > 0) i_cnt--;
      if (s_d_hs) d_cnt = 2; else if (d_cnt > 0) d_cnt--;
      br_icache_ret_last = (i_cnt == 1);
      br_dcache_ret_last = (d_cnt == 1);
    end
  end

  // Transaction-level model: what the scheduler is currently doing for whom.
  localparam int KNone = 0, KRdI = 1, KRdD = 2, KWr = 3;
  int           m_kind = KNone;
  bit           m_acked = 0;
  bit           m_last_i = 1;
  bit           m_wbv = 0;
  int           m_bypass = 0;
  logic [2:0]   m_wb_type = '0;
  logic [31:0]  m_wb_addr = '0;
  logic [3:0]   m_wb_wstrb = '0;
  logic [127:0] m_wb_data = '0;
  bit           m_cap, m_hit_i, m_hit_d, m_ok_i, m_ok_d;

  function automatic bit hits(input logic [31:0] a, input bit cap);
    return (m_wbv && (a >> LINE_OFS) == (m_wb_addr >> LINE_OFS)) ||
           (cap && (a >> LINE_OFS) == (dcache_wr_addr >> LINE_OFS));
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_kind = KNone; m_acked = 0; m_last_i = 1; m_wbv = 0; m_bypass = 0;
      m_wb_type = '0; m_wb_addr = '0; m_wb_wstrb = '0; m_wb_data = '0;
    end else begin
      m_cap   = dcache_wr_req && !m_wbv;
      m_hit_i = icache_rd_req && hits(icache_rd_addr, m_cap);
      m_hit_d = dcache_rd_req && hits(dcache_rd_addr, m_cap);
      m_ok_i  = icache_rd_req && !m_hit_i;
      m_ok_d  = dcache_rd_req && !m_hit_d;
      case (m_kind)
        KNone: begin
          if (m_wbv && (m_hit_i || m_hit_d || m_bypass == STARVE_MAX ||
                        !(icache_rd_req || dcache_rd_req))) begin
            m_kind = KWr;
            m_bypass = 0;
          end else if (m_ok_i || m_ok_d) begin
            m_kind = (m_ok_i && (!m_ok_d || !m_last_i)) ? KRdI : KRdD;
            m_last_i = (m_kind == KRdI);
            m_acked = 0;
            if (m_wbv && m_bypass < STARVE_MAX) m_bypass++;
          end
        end
        KRdI: if (!m_acked) m_acked = br_icache_rd_rdy; else if (br_icache_ret_last) m_kind = KNone;
        KRdD: if (!m_acked) m_acked = br_dcache_rd_rdy; else if (br_dcache_ret_last) m_kind = KNone;
        default: if (br_dcache_wr_rdy) begin m_kind = KNone; m_wbv = 0; end
      endcase
      if (m_cap) begin
        m_wbv = 1; m_wb_type = dcache_wr_type; m_wb_addr = dcache_wr_addr;
        m_wb_wstrb = dcache_wr_wstrb; m_wb_data = dcache_wr_data;
      end
    end
  end

  task automatic compare_loop();
    bit e_i, e_d, e_w;
    forever begin
      @(negedge aclk);
      cyc++;
      e_i = (m_kind == KRdI) && !m_acked;
      e_d = (m_kind == KRdD) && !m_acked;
      e_w = (m_kind == KWr);
      check("icache_side", {br_icache_rd_req, br_icache_rd_type, br_icache_rd_addr, icache_rd_rdy},
            {e_i, e_i ? icache_rd_type : 3'd0, e_i ? icache_rd_addr : 32'd0,
             e_i && br_icache_rd_rdy});
      check("dcache_rd_side", {br_dcache_rd_req, br_dcache_rd_type, br_dcache_rd_addr, dcache_rd_rdy},
            {e_d, e_d ? dcache_rd_type : 3'd0, e_d ? dcache_rd_addr : 32'd0,
             e_d && br_dcache_rd_rdy});
      check("dcache_wr_side", {br_dcache_wr_req, br_dcache_wr_type, br_dcache_wr_addr,
                               br_dcache_wr_wstrb, br_dcache_wr_data},
            {e_w, e_w ? m_wb_type : 3'd0, e_w ? m_wb_addr : 32'd0,
             e_w ? m_wb_wstrb : 4'd0, e_w ? m_wb_data : 128'd0});
      check("dcache_wr_rdy", dcache_wr_rdy, !m_wbv);
      s_i_req = br_icache_rd_req; s_i_hs = br_icache_rd_req && br_icache_rd_rdy;
      s_d_req = br_dcache_rd_req; s_d_hs = br_dcache_rd_req && br_dcache_rd_rdy;
      s_w_req = br_dcache_wr_req; s_w_hs = br_dcache_wr_req && br_dcache_wr_rdy;
      if (icache_rd_rdy) begin ev_log = {ev_log, "I"}; if (i_q.size() > 0) void'(i_q.pop_front()); end
      if (dcache_rd_rdy) begin ev_log = {ev_log, "D"}; if (d_q.size() > 0) void'(d_q.pop_front()); end
      if (aresetn && dcache_wr_req && dcache_wr_rdy && w_q.size() > 0) void'(w_q.pop_front());
      if (br_dcache_wr_req && br_dcache_wr_rdy) ev_log = {ev_log, "W"};
      if (cyc > 4000) begin
        $display("FAIL watchdog: cycle %0d exceeded budget 4000", cyc);
        $fatal(1, "watchdog expired");
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge aclk);
    #1;
  endtask

  task automatic wait_events(input string name, input int n, input int budget);
    int k = 0;
    while (ev_log.len() < n && k < budget) begin cycles(1); k++; end
    checks++;
    if (ev_log.len() < n) begin
      errors++;
      $display("FAIL %s: timeout with %0d events, required %0d", name, ev_log.len(), n);
    end
  endtask

  initial begin
    fork compare_loop(); join_none
    cycles(2);
    check("reset_wr_rdy", dcache_wr_rdy, 1'b1);
    check("reset_reqs", {br_icache_rd_req, br_dcache_rd_req, br_dcache_wr_req,
                         icache_rd_rdy, dcache_rd_rdy}, 5'b0);
    @(posedge aclk); #2 aresetn = 1'b1;
    cycles(2);

    // Single I-read: request visible one cycle after the scheduler sees it.
    i_q.push_back(32'h1C00_0000);
    @(negedge aclk); #1;
    check("i_lat_t", br_icache_rd_req, 1'b0);
    @(negedge aclk); #1;
    check("i_lat_t1", {br_icache_rd_req, br_icache_rd_addr, icache_rd_rdy}, {1'b1, 32'h1C00_0000, 1'b0});
    wait_events("i_only", 1, 20);
    cycles(5);
    check_log("i_only", "I");
    check("i_only_idle", br_icache_rd_req, 1'b0);
    ev_log = "";

    // Both sources held: alternation starting with D since I was granted last.
    i_q.push_back(32'h1C00_0100); i_q.push_back(32'h1C00_0200);
    d_q.push_back(32'h8000_0000); d_q.push_back(32'h8000_0010);
    wait_events("alt", 4, 100);
    cycles(5);
    check_log("alt", "DIDI");
    ev_log = "";

    // Non-conflicting read bypasses a writeback captured in the same cycle.
    w_q.push_back(32'h0000_1000); d_q.push_back(32'h0000_2000);
    wait_events("bypass", 2, 60);
    cycles(3);
    check_log("bypass", "DW");
    ev_log = "";

    // Conflicting read behind a buffered line waits for the writeback.
    i_q.push_back(32'h1C00_0040);
    cycles(1);
    w_q.push_back(32'h0000_1000); d_q.push_back(32'h0000_1008);
    wait_events("conflict", 3, 80);
    cycles(5);
    check_log("conflict", "IWD");
    ev_log = "";

    // Starvation limit: four bypassing grants, then the write goes out.
    i_q.push_back(32'h1C00_1000);
    wait_events("starve_first", 1, 20);
    w_q.push_back(32'h0000_5000);
    for (int k = 0; k < 6; k++) i_q.push_back(32'h1C00_2000 + 32'(k * 16));
    wait_events("starve", 8, 200);
    cycles(5);
    check_log("starve", "IIIIIWII");
    ev_log = "";

    // Same-cycle write and conflicting read from an empty buffer.
    w_q.push_back(32'h0000_3000); d_q.push_back(32'h0000_3004);
    wait_events("same_cycle_w", 1, 40);
    check("wr_rdy_at_hs", dcache_wr_rdy, 1'b0);
    check_log("same_cycle_w", "W");
    cycles(1);
    check("wr_rdy_after_hs", dcache_wr_rdy, 1'b1);
    wait_events("same_cycle", 2, 40);
    cycles(5);
    check_log("same_cycle", "WD");
    ev_log = "";

    // Reset while waiting for read data with a buffered writeback.
    i_q.push_back(32'h1C00_4000);
    wait_events("rst_read", 1, 20);
    w_q.push_back(32'h0000_6000);
    @(posedge aclk);
    @(posedge aclk); #2;
    check("rst_wb_held", dcache_wr_rdy, 1'b0);
    aresetn = 1'b0;
    i_q.delete(); d_q.delete(); w_q.delete();
    #1;
    check("rst_async", {dcache_wr_rdy, br_icache_rd_req, br_dcache_rd_req, br_dcache_wr_req,
                        icache_rd_rdy, br_dcache_wr_addr}, {1'b1, 4'b0, 32'd0});
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    ev_log = "";
    cycles(6);
    check_log("rst_no_stray", "");
    check("rst_quiet", {br_icache_rd_req, br_dcache_rd_req, br_dcache_wr_req, dcache_wr_rdy}, 4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
